usb3_descramble: RTL and testbench

USB3_DESCRAMBLE -- requirements
Module: usb3_descramble

---
 rtl/usb3_descramble.sv | 209 ++++++++++++++++++++
 tb/tb_usb3_descramble.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb3_descramble.sv
// usb3_descramble: receive-side USB3 descrambler with SKP removal.
// Stage 1 classifies each symbol (SKP / COM / K / data) and descrambles data
// against a 16-bit Galois LFSR (x^16+x^5+x^4+x^3+1), walking lanes 3..0.
// Stage 2 drops SKP symbols, compacts the survivors into a 7-byte accumulator
// and releases the oldest four whenever at least four are held.
// Keystream byte for a symbol is the 8 bits shifted out of the LFSR MSB while
// it advances 8 steps; bit 0 of the byte is the first bit shifted out.
module usb3_descramble #(
  parameter logic [15:0] SCRAM_INIT = 16'h7DBD
) (
  input  logic        local_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [31:0] in_data,
  input  logic [3:0]  in_datak,
  input  logic        in_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_datak,
  output logic        out_valid,
  output logic [2:0]  skp_count,
  output logic        scram_locked,
  output logic        err_skp_odd
);

  localparam logic [7:0]  SYM_SKP = 8'h3C;
  localparam logic [7:0]  SYM_COM = 8'hBC;
  localparam logic [15:0] POLY    = 16'h0039;

  // Advance the LFSR by one symbol (8 shifts).
  function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = {t[14:0], 1'b0} ^ (t[15] ? POLY : 16'h0000);
    end
    return t;
  endfunction

  // The 8 MSBs shifted out during one advance; taps never reach bit 15
  // within 8 shifts, so they are simply state[15:8] in reverse order.
  function automatic logic [7:0] lfsr_key(input logic [15:0] s);
    return {s[8], s[9], s[10], s[11], s[12], s[13], s[14], s[15]};
  endfunction

  // ---------------- stage 1 ----------------
  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] s1_data_d;
  logic [3:0]  s1_skp_d;
  logic        s1_com_d;
  logic [7:0]  sym;

  logic        s1_valid, s1_mode, s1_com;
  logic [31:0] s1_data;
  logic [3:0]  s1_datak, s1_skp;

  // Classify and descramble the incoming word lane by lane, oldest lane first.
  always_comb begin
    lfsr_d    = lfsr_q;
    s1_data_d = in_data;
    s1_skp_d  = '0;
    s1_com_d  = 1'b0;
    sym       = '0;
    if (!enable) begin
      lfsr_d = SCRAM_INIT;
    end else if (in_valid) begin
      for (int l = 3; l >= 0; l--) begin
        sym = in_data[8*l +: 8];
        if (in_datak[l] && sym == SYM_SKP) begin
          s1_skp_d[l] = 1'b1;
        end else if (in_datak[l] && sym == SYM_COM) begin
          s1_com_d = 1'b1;
          lfsr_d   = SCRAM_INIT;
        end else begin
          if (!in_datak[l]) s1_data_d[8*l +: 8] = sym ^ lfsr_key(lfsr_d);
          lfsr_d = lfsr_adv8(lfsr_d);
        end
      end
    end
  end

  // Stage-1 pipeline register and LFSR state.
  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      lfsr_q   <= SCRAM_INIT;
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_com   <= 1'b0;
      s1_data  <= '0;
      s1_datak <= '0;
      s1_skp   <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      s1_valid <= in_valid;
      s1_mode  <= enable;
      s1_com   <= s1_com_d;
      s1_data  <= s1_data_d;
      s1_datak <= in_datak;
      s1_skp   <= s1_skp_d;
    end
  end

  // ---------------- stage 2 ----------------
  logic [7:0]  acc_data_q [7];
  logic [6:0]  acc_k_q;
  logic [2:0]  acc_depth_q;
  logic        run_odd_q;

  logic [7:0]  acc_data_d [7];
  logic [6:0]  acc_k_d;
  logic [2:0]  acc_depth_d;
  logic        run_odd_d;

  logic [7:0]  mrg_data [7];
  logic [6:0]  mrg_k;
  logic [3:0]  mrg_cnt;

  logic [31:0] out_data_d;
  logic [3:0]  out_datak_d;
  logic        out_valid_d;
  logic [2:0]  skp_count_d;
  logic        err_d;
  logic        locked_d;

  // Strip SKPs, append survivors behind the carried-over symbols and pop a
  // full word when four or more are available. Bypass mode empties the
  // accumulator so nothing partial survives a mode change.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      mrg_data[i]   = acc_data_q[i];
      acc_data_d[i] = acc_data_q[i];
    end
    mrg_k       = acc_k_q;
    mrg_cnt     = {1'b0, acc_depth_q};
    acc_k_d     = acc_k_q;
    acc_depth_d = acc_depth_q;
    run_odd_d   = run_odd_q;
    out_data_d  = out_data;
    out_datak_d = out_datak;
    out_valid_d = 1'b0;
    skp_count_d = '0;
    err_d       = 1'b0;
    locked_d    = scram_locked | s1_com;
    if (!s1_mode) begin
      out_valid_d = s1_valid;
      out_data_d  = s1_data;
      out_datak_d = s1_datak;
      acc_depth_d = '0;
      run_odd_d   = 1'b0;
    end else if (s1_valid) begin
      for (int l = 3; l >= 0; l--) begin
        if (s1_skp[l]) begin
          skp_count_d = skp_count_d + 3'd1;
          run_odd_d   = !run_odd_d;
        end else begin
          if (run_odd_d) err_d = 1'b1;
          run_odd_d = 1'b0;
          if (mrg_cnt < 4'd7) begin
            mrg_data[mrg_cnt[2:0]] = s1_data[8*l +: 8];
            mrg_k[mrg_cnt[2:0]]    = s1_datak[l];
          end
          mrg_cnt = mrg_cnt + 4'd1;
        end
      end
      if (mrg_cnt >= 4'd4) begin
        out_valid_d = 1'b1;
        out_data_d  = {mrg_data[0], mrg_data[1], mrg_data[2], mrg_data[3]};
        out_datak_d = {mrg_k[0], mrg_k[1], mrg_k[2], mrg_k[3]};
        for (int i = 0; i < 7; i++) acc_data_d[i] = 8'h00;
        acc_data_d[0] = mrg_data[4];
        acc_data_d[1] = mrg_data[5];
        acc_data_d[2] = mrg_data[6];
        acc_k_d       = {4'b0000, mrg_k[6:4]};
        acc_depth_d   = 3'(mrg_cnt - 4'd4);
      end else begin
        for (int i = 0; i < 7; i++) acc_data_d[i] = mrg_data[i];
        acc_k_d     = mrg_k;
        acc_depth_d = mrg_cnt[2:0];
      end
    end
  end

  // Stage-2 registers: accumulator, SKP run parity and all outputs.
  always_ff @(posedge local_clk) begin
    if (!reset_n) begin
      acc_data_q   <= '{default: 8'h00};
      acc_k_q      <= '0;
      acc_depth_q  <= '0;
      run_odd_q    <= 1'b0;
      out_data     <= '0;
      out_datak    <= '0;
      out_valid    <= 1'b0;
      skp_count    <= '0;
      err_skp_odd  <= 1'b0;
      scram_locked <= 1'b0;
    end else begin
      acc_data_q   <= acc_data_d;
      acc_k_q      <= acc_k_d;
      acc_depth_q  <= acc_depth_d;
      run_odd_q    <= run_odd_d;
      out_data     <= out_data_d;
      out_datak    <= out_datak_d;
      out_valid    <= out_valid_d;
      skp_count    <= skp_count_d;
      err_skp_odd  <= err_d;
      scram_locked <= locked_d;
    end
  end

endmodule

// File: tb/tb_usb3_descramble.sv
// Bench for usb3_descramble: directed scenarios, scrambled loopback and a
// randomized run, all compared against a symbol-queue reference model.
module tb_usb3_descramble;

  localparam logic [15:0] INIT = 16'h7DBD;

  logic        local_clk = 1'b0;
  logic        reset_n, enable, in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_datak;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        out_valid, scram_locked, err_skp_odd;
  logic [2:0]  skp_count;

  usb3_descramble #(.SCRAM_INIT(INIT)) dut (
    .local_clk(local_clk), .reset_n(reset_n), .enable(enable),
    .in_data(in_data), .in_datak(in_datak), .in_valid(in_valid),
    .out_data(out_data), .out_datak(out_datak), .out_valid(out_valid),
    .skp_count(skp_count), .scram_locked(scram_locked), .err_skp_odd(err_skp_odd)
  );

  always #5 local_clk = ~local_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          valid;
    logic [31:0] data;
    logic [3:0]  k;
    int          skp;
    bit          err;
    bit          locked;
  } exp_t;

  // Reference model state: a plain symbol FIFO instead of a fixed accumulator.
  logic [15:0] m_lfsr = INIT;
  logic [7:0]  q_sym[$];
  logic        q_k[$];
  bit          m_run_odd = 0;
  bit          m_locked = 0;
  exp_t        pending;
  bit          lb_phase = 0;
  int          lb_words = 0;

  // Serial keystream: shift 8 times, collecting the MSB before each shift.
  function automatic logic [23:0] ks_step(input logic [15:0] s);
    logic [7:0]  key;
    logic [15:0] t;
    bit          fb;
    t = s;
    key = '0;
    for (int i = 0; i < 8; i++) begin
      fb = t[15];
      key[i] = fb;
      t = t << 1;
      if (fb) t = t ^ 16'h0039;
    end
    return {key, t};
  endfunction

  task automatic model(input bit rst_n, input bit en, input bit vld,
                       input logic [31:0] d, input logic [3:0] k, output exp_t e);
    logic [7:0]  sym;
    logic [23:0] r;
    e = '{default: 0};
    if (!rst_n) begin
      m_lfsr = INIT; q_sym.delete(); q_k.delete(); m_run_odd = 0; m_locked = 0;
      e.rst = 1;
      return;
    end
    if (!en) begin
      m_lfsr = INIT; q_sym.delete(); q_k.delete(); m_run_odd = 0;
      e.valid = vld; e.data = d; e.k = k; e.locked = m_locked;
      return;
    end
    if (vld) begin
      for (int l = 3; l >= 0; l--) begin
        sym = d[8*l +: 8];
        if (k[l] && sym == 8'h3C) begin
          e.skp++;
          m_run_odd = !m_run_odd;
        end else begin
          if (m_run_odd) e.err = 1;
          m_run_odd = 0;
          if (k[l] && sym == 8'hBC) begin
            m_locked = 1;
            m_lfsr = INIT;
            q_sym.push_back(sym);
            q_k.push_back(1'b1);
          end else begin
            r = ks_step(m_lfsr);
            m_lfsr = r[15:0];
            q_sym.push_back(k[l] ? sym : (sym ^ r[23:16]));
            q_k.push_back(k[l]);
          end
        end
      end
    end
    if (q_sym.size() >= 4) begin
      e.valid = 1;
      for (int j = 3; j >= 0; j--) begin
        e.data[8*j +: 8] = q_sym.pop_front();
        e.k[j] = q_k.pop_front();
      end
    end
    e.locked = m_locked;
  endtask

  task automatic compare(input exp_t x);
    check("out_valid", {31'd0, out_valid}, {31'd0, x.valid});
    check("skp_count", {29'd0, skp_count}, 32'(x.skp));
    check("err_skp_odd", {31'd0, err_skp_odd}, {31'd0, x.err});
    check("scram_locked", {31'd0, scram_locked}, {31'd0, x.locked});
    if (x.rst) begin
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_datak", {28'd0, out_datak}, 32'h0);
    end else if (x.valid) begin
      check("out_data", out_data, x.data);
      check("out_datak", {28'd0, out_datak}, {28'd0, x.k});
      if (lb_phase && x.k == 4'h0) begin
        check("loop_zero", out_data, 32'h0);
        lb_words++;
      end
    end
  endtask

  // One clock: apply inputs, step the model, check the word from two stages back.
  task automatic drive(input bit rst_n, input bit en, input bit vld,
                       input logic [31:0] d, input logic [3:0] k);
    exp_t e;
    reset_n = rst_n; enable = en; in_valid = vld; in_data = d; in_datak = k;
    model(rst_n, en, vld, d, k, e);
    @(posedge local_clk);
    #1;
    if (e.rst) compare(e);
    else compare(pending);
    pending = e;
  endtask

  logic [15:0] sc;
  logic [23:0] r;
  logic [31:0] w_data;
  logic [3:0]  w_k;
  int          zeros_sent;
  int          w;
  bit          en_r;
  int          sel;

  initial begin
    pending = '{default: 0};
    pending.rst = 1;
    repeat (3) drive(0, 1, 0, 32'h0, 4'h0);

    // COM word, then SKP pair mid-word, full SKP word, invalid cycles.
    drive(1, 1, 1, 32'hBCBCBCBC, 4'hF);
    drive(1, 1, 1, 32'h3C3CD0D1, 4'hC);
    drive(1, 1, 1, 32'hD2D3D4D5, 4'h0);
    drive(1, 1, 1, 32'h3C3C3C3C, 4'hF);
    drive(1, 1, 0, $urandom, 4'($urandom));
    drive(1, 1, 0, $urandom, 4'($urandom));
    // COM in lane 1 with two symbols still buffered.
    drive(1, 1, 1, 32'h1122BC33, 4'b0010);
    drive(1, 1, 0, 32'h0, 4'h0);
    // Odd SKP run, three buffered, then reset discards them.
    drive(0, 1, 0, 32'h0, 4'h0);
    drive(1, 1, 1, 32'h3CD0D1D2, 4'h8);
    drive(1, 1, 0, 32'h0, 4'h0);
    drive(0, 1, 0, 32'h0, 4'h0);
    drive(1, 1, 1, 32'hA0A1A2A3, 4'h0);
    drive(1, 1, 0, 32'h0, 4'h0);
    drive(1, 1, 0, 32'h0, 4'h0);
    // Bypass and back.
    drive(1, 0, 1, 32'h3C3C1234, 4'hC);
    drive(1, 0, 1, 32'hCAFEF00D, 4'h5);
    drive(1, 1, 1, 32'h01020304, 4'h0);
    drive(1, 1, 1, 32'h05060708, 4'h0);
    drive(1, 1, 0, 32'h0, 4'h0);

    // Loopback: scramble zeros with an independent keystream walk.
    drive(0, 1, 0, 32'h0, 4'h0);
    lb_phase = 1;
    lb_words = 0;
    sc = INIT;
    drive(1, 1, 1, 32'hBCBCBCBC, 4'hF);
    zeros_sent = 0;
    w = 0;
    while (zeros_sent < 256) begin
      w_data = '0;
      w_k = '0;
      for (int l = 3; l >= 0; l--) begin
        if ((w % 5 == 2 && l >= 2) || zeros_sent >= 256) begin
          w_data[8*l +: 8] = 8'h3C;
          w_k[l] = 1'b1;
        end else begin
          r = ks_step(sc);
          sc = r[15:0];
          w_data[8*l +: 8] = 8'h00 ^ r[23:16];
          zeros_sent++;
        end
      end
      drive(1, 1, 1, w_data, w_k);
      if (w % 7 == 0) drive(1, 1, 0, $urandom, 4'($urandom));
      w++;
    end
    repeat (3) drive(1, 1, 0, 32'h0, 4'h0);
    lb_phase = 0;
    check("loop_words", 32'(lb_words), 32'd64);

    // Randomized run.
    en_r = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 150 == 0) en_r = !en_r;
      w_data = '0;
      w_k = '0;
      for (int l = 0; l < 4; l++) begin
        sel = int'($urandom % 16);
        if (sel < 3) begin
          w_data[8*l +: 8] = 8'h3C; w_k[l] = 1'b1;
        end else if (sel == 3 && $urandom % 4 == 0) begin
          w_data[8*l +: 8] = 8'hBC; w_k[l] = 1'b1;
        end else if (sel == 4) begin
          w_data[8*l +: 8] = 8'hF7; w_k[l] = 1'b1;
        end else begin
          w_data[8*l +: 8] = 8'($urandom);
        end
      end
      drive(($urandom % 200) != 0, en_r, ($urandom % 4) != 0, w_data, w_k);
    end
    repeat (3) drive(1, 1, 0, 32'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
